// File: rtl/osc_period_meter_if.sv
// osc_period_meter_if
// Result channel of the oscillator period meter: one measured period and its
// high phase, a valid/ready handshake, and the two sticky status flags.
//   period    : clock cycles between two rising edges of the oscillator
//   high_time : clock cycles the oscillator was high within that period
//   valid     : result held on period/high_time
//   ready     : consumer accepts the held result
//   overrun   : a completed period was dropped while a result was held
//   stalled   : the period counter saturated with no rising edge
// The meter drives the master modport; the consumer uses the slave modport.
interface osc_period_meter_if #(
  parameter int W = 16
);
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         ready;
  logic         overrun;
  logic         stalled;

  modport master (
    output period,
    output high_time,
    output valid,
    output overrun,
    output stalled,
    input  ready
  );

  modport slave (
    input  period,
    input  high_time,
    input  valid,
    input  overrun,
    input  stalled,
    output ready
  );
endinterface

// File: rtl/osc_period_meter.sv
// osc_period_meter
// Measures a free-running oscillator in system clock cycles. The oscillator
// line is synchronised, rising edges are detected, and the cycles per period
// and per high phase are counted. Every completed period is offered as a
// single-entry valid/ready result with sticky overrun and stall flags.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   osc_in : oscillator output, asynchronous to clk
//   enable : measurement enable
//   res    : result channel (period, high_time, valid, ready, overrun, stalled)
module osc_period_meter #(
  parameter int W    = 16,
  parameter int SYNC = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  osc_in,
  input  logic                  enable,
  osc_period_meter_if.master    res
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [SYNC-1:0] sync_q, sync_d;
  logic            s_d_q, s_d_d;
  logic            s;
  logic            rise;

  state_t          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    hcnt_q, hcnt_d;

  logic [W-1:0]    period_q, period_d;
  logic [W-1:0]    high_q, high_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            stalled_q, stalled_d;

  logic            capture;
  logic            stall;

  // Synchroniser chain and edge detector
  always_comb begin
    sync_d = {sync_q[SYNC-2:0], osc_in};
    s      = sync_q[SYNC-1];
    s_d_d  = s;
    rise   = s & ~s_d_q;
  end

  // Measurement FSM and counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    capture = 1'b0;
    stall   = 1'b0;

    if (!enable) begin
      // Disabling discards any partial period but leaves the result alone
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            // The rise cycle itself is the first (high) cycle of the period
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // An edge at a saturated count still closes a valid period
            capture = 1'b1;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            stall   = 1'b1;
            cnt_d   = '0;
            hcnt_d  = '0;
            state_d = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (s && (hcnt_q != CNT_MAX)) begin
              hcnt_d = hcnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // Single-entry result register with sticky flags
  always_comb begin
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    stalled_d = stalled_q;

    if (capture) begin
      if (!valid_q || res.ready) begin
        period_d  = cnt_q;
        high_d    = hcnt_q;
        valid_d   = 1'b1;
        stalled_d = 1'b0;
      end else begin
        // Held result not yet taken: drop the new one and remember it
        overrun_d = 1'b1;
      end
    end else if (valid_q && res.ready) begin
      valid_d = 1'b0;
    end

    if (stall) begin
      stalled_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      s_d_q     <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      s_d_q     <= s_d_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      stalled_q <= stalled_d;
    end
  end

  assign res.period    = period_q;
  assign res.high_time = high_q;
  assign res.valid     = valid_q;
  assign res.overrun   = overrun_q;
  assign res.stalled   = stalled_q;

endmodule

// File: tb/tb_osc_period_meter.sv
// tb_osc_period_meter
// Drives osc_period_meter (W=4 so saturation is reachable) with directed
// waveforms followed by randomised periods, duty cycles, ready, enable and
// reset, and compares every cycle against a reference model that keeps the
// synchronised samples of the current period in a queue.
module tb_osc_period_meter;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int MAXC = (1 << W) - 1;

  logic clk;
  logic rst;
  logic osc_in;
  logic enable;
  logic ready;

  osc_period_meter_if #(.W(W)) bus ();
  assign bus.ready = ready;

  osc_period_meter #(.W(W), .SYNC(SYNC)) dut (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .enable (enable),
    .res    (bus.master)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Oscillator request (period 0 means hold at level osc_hi != 0)
  int osc_per = 10;
  int osc_hi  = 5;

  // Reference model state
  bit model_live = 1'b0;
  bit m_pipe [SYNC];
  bit m_sprev;
  bit m_armed;
  bit m_measuring;
  bit m_samples [$];
  bit m_valid;
  int m_period;
  int m_high;
  bit m_overrun;
  bit m_stalled;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input int per, input int hi, input bit rdy, input bit en);
    osc_per = per;
    osc_hi  = hi;
    ready   = rdy;
    enable  = en;
  endtask

  task automatic waitValid(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.valid) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_timeout"}, int'(bus.valid), 1);
  endtask

  // One reference step per clock edge, using the inputs of the cycle that ends
  task automatic modelStep();
    bit s, rise, cap, stall;
    int cp, ch;
    if (rst) begin
      foreach (m_pipe[k]) m_pipe[k] = 1'b0;
      m_sprev     = 1'b0;
      m_armed     = 1'b0;
      m_measuring = 1'b0;
      m_samples.delete();
      m_valid     = 1'b0;
      m_period    = 0;
      m_high      = 0;
      m_overrun   = 1'b0;
      m_stalled   = 1'b0;
      model_live  = 1'b1;
      return;
    end
    s     = m_pipe[SYNC-1];
    rise  = s && !m_sprev;
    cap   = 1'b0;
    stall = 1'b0;
    cp    = 0;
    ch    = 0;
    if (!enable) begin
      m_armed     = 1'b0;
      m_measuring = 1'b0;
      m_samples.delete();
    end else if (!m_armed && !m_measuring) begin
      m_armed = 1'b1;
    end else if (m_armed) begin
      if (rise) begin
        m_armed     = 1'b0;
        m_measuring = 1'b1;
        m_samples.delete();
        m_samples.push_back(1'b1);
      end
    end else begin
      if (rise) begin
        cap = 1'b1;
        cp  = m_samples.size();
        foreach (m_samples[k]) ch += int'(m_samples[k]);
        m_samples.delete();
        m_samples.push_back(1'b1);
      end else if (m_samples.size() == MAXC) begin
        stall       = 1'b1;
        m_measuring = 1'b0;
        m_armed     = 1'b1;
        m_samples.delete();
      end else begin
        m_samples.push_back(s);
      end
    end
    if (cap) begin
      if (!m_valid || ready) begin
        m_valid   = 1'b1;
        m_period  = cp;
        m_high    = ch;
        m_stalled = 1'b0;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    if (stall) m_stalled = 1'b1;
    m_sprev = s;
    for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = osc_in;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        checkOutput("valid", int'(bus.valid), int'(m_valid));
        checkOutput("overrun", int'(bus.overrun), int'(m_overrun));
        checkOutput("stalled", int'(bus.stalled), int'(m_stalled));
        if (m_valid) begin
          checkOutput("period", int'(bus.period), m_period);
          checkOutput("high_time", int'(bus.high_time), m_high);
        end
      end
    end
  end

  // Oscillator generator, changes only on the falling clock edge
  initial begin
    int cur_per, cur_hi, phase;
    cur_per = -1;
    cur_hi  = -1;
    phase   = 0;
    osc_in  = 1'b0;
    forever begin
      @(negedge clk);
      if (osc_per != cur_per || osc_hi != cur_hi) begin
        cur_per = osc_per;
        cur_hi  = osc_hi;
        phase   = 0;
      end
      if (cur_per <= 0) begin
        osc_in = (cur_hi != 0);
      end else begin
        osc_in = (phase < cur_hi);
        phase  = (phase + 1) % cur_per;
      end
    end
  end

  initial begin
    int p, h;
    rst = 1'b1;
    applyStimulus(10, 5, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", int'(bus.valid), 0);
    checkOutput("reset_period", int'(bus.period), 0);
    checkOutput("reset_overrun", int'(bus.overrun), 0);
    checkOutput("reset_stalled", int'(bus.stalled), 0);
    rst = 1'b0;

    // Nominal 10-clock period, 5 high
    waitValid(40, "nominal_first");
    waitValid(15, "nominal_second");
    checkOutput("nominal_period", int'(bus.period), 10);
    checkOutput("nominal_high", int'(bus.high_time), 5);
    checkOutput("nominal_overrun", int'(bus.overrun), 0);
    checkOutput("nominal_stalled", int'(bus.stalled), 0);

    // Duty-cycle sweep, each checked on the third result after switching
    applyStimulus(3, 1, 1'b1, 1'b1);
    repeat (3) waitValid(20, "sweep3");
    checkOutput("sweep3_period", int'(bus.period), 3);
    checkOutput("sweep3_high", int'(bus.high_time), 1);
    applyStimulus(2, 1, 1'b1, 1'b1);
    repeat (3) waitValid(20, "sweep2");
    checkOutput("sweep2_period", int'(bus.period), 2);
    checkOutput("sweep2_high", int'(bus.high_time), 1);
    applyStimulus(7, 3, 1'b1, 1'b1);
    repeat (3) waitValid(20, "sweep7a");
    checkOutput("sweep7a_period", int'(bus.period), 7);
    checkOutput("sweep7a_high", int'(bus.high_time), 3);
    applyStimulus(7, 4, 1'b1, 1'b1);
    repeat (3) waitValid(20, "sweep7b");
    checkOutput("sweep7b_period", int'(bus.period), 7);
    checkOutput("sweep7b_high", int'(bus.high_time), 4);

    // Overrun: hold the result across several periods
    applyStimulus(10, 5, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    ready = 1'b0;
    repeat (35) @(negedge clk);
    checkOutput("overrun_valid", int'(bus.valid), 1);
    checkOutput("overrun_period", int'(bus.period), 10);
    checkOutput("overrun_flag", int'(bus.overrun), 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    waitValid(20, "overrun_again");
    checkOutput("overrun_again_period", int'(bus.period), 10);

    // Stall: one edge, then held high until the counter saturates
    applyStimulus(0, 1, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    checkOutput("stall_flag", int'(bus.stalled), 1);
    checkOutput("stall_valid", int'(bus.valid), 0);
    applyStimulus(6, 3, 1'b1, 1'b1);
    waitValid(40, "stall_resume");
    checkOutput("stall_resume_period", int'(bus.period), 6);
    checkOutput("stall_resume_high", int'(bus.high_time), 3);
    checkOutput("stall_resume_flag", int'(bus.stalled), 0);

    // Reset mid-period with a held result
    applyStimulus(10, 5, 1'b1, 1'b1);
    repeat (25) @(negedge clk);
    ready = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_valid", int'(bus.valid), 0);
    checkOutput("rst_period", int'(bus.period), 0);
    checkOutput("rst_high", int'(bus.high_time), 0);
    checkOutput("rst_overrun", int'(bus.overrun), 0);
    rst   = 1'b0;
    ready = 1'b1;
    waitValid(40, "rst_resume");
    checkOutput("rst_resume_period", int'(bus.period), 10);

    // Enable drop while a result is held
    repeat (25) @(negedge clk);
    ready = 1'b0;
    repeat (12) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    checkOutput("en_held_valid", int'(bus.valid), 1);
    checkOutput("en_held_period", int'(bus.period), 10);
    ready = 1'b1;
    @(negedge clk);
    waitValid(40, "en_resume");
    checkOutput("en_resume_period", int'(bus.period), 10);

    // Randomised traffic, checked cycle by cycle against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 40 == 0) begin
        p = $urandom_range(17, 2);
        h = $urandom_range(p - 1, 1);
        osc_per = p;
        osc_hi  = h;
      end
      ready  = ($urandom_range(9, 0) < 7);
      enable = ($urandom_range(99, 0) != 0);
      rst    = ($urandom_range(499, 0) == 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
